// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access sequencer: MemOp codes,
// FSM states, latched request record and the default bus timeout.
package mem_pkg;

  localparam int NUM_LANES       = 4;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Fields still needed after the bus regs have captured address/data.
  typedef struct packed {
    logic       wr;
    logic [2:0] op;
    logic [1:0] alo;
  } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/grant/response data bus between the sequencer and memory.
interface mem_access_ctrl_if;
  import mem_pkg::*;

  logic                 bus_req;
  logic                 bus_we;
  logic [31:0]          bus_addr;
  logic [NUM_LANES-1:0] bus_be;
  logic [31:0]          bus_wdata;
  logic                 bus_gnt;
  logic                 bus_rvalid;
  logic [31:0]          bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: byte enables, store replication,
// load extract/extend and misalign/illegal-op detection.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]                  op,
  input  logic [1:0]                  alo,
  input  logic [31:0]                 wdata,
  input  logic [31:0]                 rword,
  output logic [NUM_LANES-1:0]        be,
  output logic [NUM_LANES-1:0][7:0]   wrep,
  output logic [31:0]                 rext,
  output logic                        fault
);
  // sz: 0 byte, 1 half, 2 word
  logic [1:0]  sz;
  logic [31:0] sh;

  // access size and fault classification
  always_comb begin
    sz    = 2'd2;
    fault = 1'b1;
    case (op)
      MOP_B, MOP_BU: begin sz = 2'd0; fault = 1'b0;    end
      MOP_H, MOP_HU: begin sz = 2'd1; fault = alo[0];  end
      MOP_W:         begin sz = 2'd2; fault = |alo;    end
      default:       begin sz = 2'd2; fault = 1'b1;    end
    endcase
  end

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LN = 2'(i);
      assign be[i]   = (sz == 2'd0) ? (alo == LN) :
                       (sz == 2'd1) ? (alo[1] == LN[1]) : 1'b1;
      assign wrep[i] = (sz == 2'd0) ? wdata[7:0] :
                       (sz == 2'd1) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
    end
  endgenerate

  assign sh = rword >> {alo, 3'b000};

  // load extract and extend; illegal ops return zero
  always_comb begin
    rext = '0;
    case (op)
      MOP_B:   rext = {{24{sh[7]}}, sh[7:0]};
      MOP_BU:  rext = {24'b0, sh[7:0]};
      MOP_H:   rext = {{16{sh[15]}}, sh[15:0]};
      MOP_HU:  rext = {16'b0, sh[15:0]};
      MOP_W:   rext = sh;
      default: rext = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: latches one access, runs the bus
// handshake, stalls the core and returns the extended load result.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              misalign,
  output logic              bus_err,
  mem_access_ctrl_if.master bus
);
  state_t   state, nxt;
  mem_req_t req;
  logic [7:0]  cnt;
  logic        mis_q, err_q;
  logic [31:0] rdata_q;

  logic [2:0]                 op_sel;
  logic [1:0]                 alo_sel;
  logic [NUM_LANES-1:0]       be_c;
  logic [NUM_LANES-1:0][7:0]  wrep_c;
  logic [31:0]                rext_c;
  logic                       fault_c;
  logic accept, tmo, cap_rd, set_err;

  // In IDLE the lane logic looks at the live core inputs (to classify and
  // build be/wdata); afterwards it decodes the latched op for the load.
  assign op_sel  = (state == S_IDLE) ? mem_op    : req.op;
  assign alo_sel = (state == S_IDLE) ? addr[1:0] : req.alo;

  mem_lane_align u_align (
    .op    (op_sel),
    .alo   (alo_sel),
    .wdata (wdata),
    .rword (bus.bus_rdata),
    .be    (be_c),
    .wrep  (wrep_c),
    .rext  (rext_c),
    .fault (fault_c)
  );

  // Last permitted REQ/WAIT cycle; counter holds cycles already spent.
  assign tmo = (cnt == 8'(TIMEOUT_CYC - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // next state and per-cycle strobes; a late grant loses to the timeout,
  // but a response arriving on the last cycle still completes normally
  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    cap_rd  = 1'b0;
    set_err = 1'b0;
    case (state)
      S_IDLE: if (mem_en) begin
        accept = 1'b1;
        nxt    = fault_c ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (tmo) begin
          set_err = 1'b1;
          nxt     = S_DONE;
        end else if (bus.bus_gnt) begin
          nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.bus_rvalid) begin
          cap_rd = 1'b1;
          nxt    = S_DONE;
        end else if (tmo) begin
          set_err = 1'b1;
          nxt     = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // access latches, bus drive registers, timeout counter and result
  always_ff @(posedge clk) begin
    if (rst) begin
      req           <= '0;
      cnt           <= '0;
      mis_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      if (state == S_REQ || state == S_WAIT) cnt <= cnt + 8'd1;
      else                                   cnt <= '0;

      if (accept) begin
        req     <= '{wr: mem_wr, op: mem_op, alo: addr[1:0]};
        mis_q   <= fault_c;
        err_q   <= 1'b0;
        rdata_q <= '0;
        // faulted accesses never touch the bus
        if (!fault_c) begin
          bus.bus_req   <= 1'b1;
          bus.bus_we    <= mem_wr;
          bus.bus_addr  <= {addr[31:2], 2'b00};
          bus.bus_be    <= be_c;
          bus.bus_wdata <= wrep_c;
        end
      end

      if (state == S_REQ && nxt != S_REQ) bus.bus_req <= 1'b0;
      if (set_err)                        err_q       <= 1'b1;
      if (cap_rd && !req.wr)              rdata_q     <= rext_c;
    end
  end

  assign done     = (state == S_DONE);
  assign misalign = done & mis_q;
  assign bus_err  = done & err_q;
  assign rdata    = done ? rdata_q : '0;
  assign stall    = mem_en & (state != S_DONE);
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access sequencer between the RV32I core's load/store controls (MemWr, MemtoReg, MemOp) and a request/grant/response data bus. It latches one access, drives the bus handshake, stalls the core until completion, generates byte enables and lane-replicated store data, and returns the sign- or zero-extended load result. It also detects misaligned accesses, illegal MemOp codes and bus timeouts.

## Interface
- TIMEOUT_CYC, 255: cycles spent in REQ+WAIT before abort; 8-bit counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  core requests an access this cycle (MemWr | MemtoReg).
- mem_wr  in  1  1 = store, 0 = load.
- mem_op  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  hold PC/pipeline; combinational.
- rdata  out  32  extended load data; valid while done=1, else 0.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  pulses with done on misaligned or illegal access.
- bus_err  out  1  pulses with done on timeout.
- bus_req  out  1  registered request; held until bus_gnt.
- bus_we  out  1  write enable, valid with bus_req.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  response/write-ack; never in the same cycle as bus_gnt.
- bus_rdata  in  32  read word.

## Operation
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE: on mem_en, latch mem_wr, mem_op, addr, wdata. Legal and aligned -> REQ; misaligned (h: addr[0]; w: addr[1:0]!=0) or illegal op -> DONE with misalign set, no bus activity.
- REQ: bus_req=1; bus_gnt -> WAIT.
- WAIT: bus_rvalid -> DONE; capture bus_rdata (loads). Stores also wait for rvalid.
- DONE: done=1, flags valid, -> IDLE unconditionally.
- stall = mem_en & (state != DONE).
- Timeout counter clears in IDLE, increments in REQ/WAIT; reaching TIMEOUT_CYC -> DONE with bus_err=1, rdata=0, bus_req dropped.
- bus_be: b 4'b0001<<addr[1:0]; h 4'b0011<<{addr[1],1'b0}; w 4'b1111.
- bus_wdata: b {4{wdata[7:0]}}; h {2{wdata[15:0]}}; w wdata.
- Load: shift bus_rdata right by addr[1:0]*8; b/h sign-extend bit 7/15; bu/hu zero-extend; w pass-through. Stores: rdata=0.
- Faulted accesses return rdata=0.

## Timing
- Reset: state IDLE; stall (if mem_en=0), done, misalign, bus_err, bus_req, bus_we=0; bus_addr, bus_be, bus_wdata, rdata, counter=0.
- Minimum latency: mem_en at cycle 0, bus_req cycle 1 (gnt same cycle), rvalid cycle 2, done cycle 3; stall high cycles 0-2.
- Misaligned/illegal: done+misalign at cycle 1; stall high cycle 0 only.
- mem_en dropping mid-access: access completes, done still pulses.
- bus_rvalid outside WAIT ignored; bus_gnt outside REQ ignored.
- Reset mid-access: IDLE next edge, bus_req low; late rvalid ignored.
- Back-to-back: new mem_en accepted in the IDLE cycle after DONE.

## Structure
- Shared package mem_pkg: MemOp encodings (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU), state enum, TIMEOUT_CYC default.
- Sub-module mem_lane_align (combinational): byte enables, store replication, load extract/extend, misalign/illegal detect.
- Top holds FSM, latches, counter, handshake.

## Test plan
- lw addr 0x1004, gnt cycle 1, rvalid cycle 2 data 0xDEADBEEF -> done cycle 3, rdata 0xDEADBEEF, bus_be 1111, stall cycles 0-2.
- lb addr 0x1003, rdata 0x80112233 -> rdata 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x1002 -> 0x00008011.
- sb addr 0x2001 wdata 0x000000A5 -> bus_be 0010, bus_wdata 0xA5A5A5A5, bus_we=1, rdata 0.
- lh addr 0x1001 -> no bus_req, done+misalign cycle 1; mem_op 011 -> same.
- gnt withheld 255 cycles -> bus_err+done pulse, bus_req drops, rdata 0.
- rst during WAIT, then rvalid -> IDLE, no done; next lw completes normally.
